// File: rtl/run_len_meter_pkg.sv
// run_len_meter_pkg: shared FSM state type, run record layout and widths.
// Rev 1.0
`default_nettype none

package run_len_meter_pkg;

  localparam int MAX_CNT_W  = 32;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SAT  = 2'd2
  } run_state_t;

  // Record layout sized to the widest supported counter; users slice to CNT_W.
  typedef struct packed {
    logic                 sat;
    logic [MAX_CNT_W-1:0] len;
  } run_rec_t;

endpackage

`default_nettype wire

// File: rtl/run_len_fifo.sv
// run_len_fifo: synchronous occupancy-counted FIFO; a push into a full FIFO
// is accepted only when a pop happens in the same cycle, otherwise flagged.
`default_nettype none

module run_len_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_rej
);
  import run_len_meter_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_full;
  logic w_pop;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == c_DEPTH);
  assign w_pop     = i_pop && !o_empty;
  assign w_push_ok = i_push && (!w_full || w_pop);
  assign o_rej     = i_push && !w_push_ok;
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // When full with a pop, wr_ptr == rd_ptr: the head is read before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/run_len_meter.sv
// run_len_meter: measures high-run lengths on `in` and queues records for a valid/ready consumer.
// Optional RUN_LEN_METER_DROPCNT_EN adds a saturating count of records lost to a full FIFO.
`default_nettype none

module run_len_meter
  import run_len_meter_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  output logic             len_valid,
  input  logic             len_ready,
  output logic [CNT_W-1:0] len_data,
  output logic             len_sat,
  output logic             busy
`ifdef RUN_LEN_METER_DROPCNT_EN
  ,
  output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  run_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_push;
  run_rec_t         w_push_rec;
  logic [CNT_W:0]   w_rdata;
  logic             w_empty;
  logic             w_rej;

  assign w_cnt_inc = r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_push      = 1'b0;
    w_push_rec  = '0;
    case (r_state)
      IDLE: begin
        if (in) begin
          w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          w_state_nxt = (CNT_W == 1) ? SAT : RUN;
        end
      end
      RUN: begin
        if (in) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == c_MAX) w_state_nxt = SAT;
        end else begin
          w_push         = 1'b1;
          w_push_rec.len = MAX_CNT_W'(r_cnt);
          w_cnt_nxt      = '0;
          w_state_nxt    = IDLE;
        end
      end
      SAT: begin
        if (!in) begin
          w_push         = 1'b1;
          w_push_rec.sat = 1'b1;
          w_push_rec.len = MAX_CNT_W'(c_MAX);
          w_cnt_nxt      = '0;
          w_state_nxt    = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  run_len_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CNT_W + 1)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata ({w_push_rec.sat, w_push_rec.len[CNT_W-1:0]}),
    .i_pop   (len_ready),
    .o_rdata (w_rdata),
    .o_empty (w_empty),
    .o_rej   (w_rej)
  );

  assign len_valid = !w_empty;
  assign len_data  = w_rdata[CNT_W-1:0];
  assign len_sat   = w_rdata[CNT_W];
  assign busy      = (r_state != IDLE);

`ifdef RUN_LEN_METER_DROPCNT_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop_cnt <= '0;
    end else if (w_rej && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_cnt = r_drop_cnt;

  logic w_unused;
  assign w_unused = ^w_push_rec.len[MAX_CNT_W-1:CNT_W];
`else
  // Rejected records are simply lost in this build.
  logic w_unused;
  assign w_unused = w_rej ^ (^w_push_rec.len[MAX_CNT_W-1:CNT_W]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_run_len_meter.sv
// tb_run_len_meter: directed self-checking bench for run_len_meter (CNT_W=4, DEPTH=4).
`default_nettype none

module tb_run_len_meter;

  localparam int CNT_W = 4;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst;
  logic             in;
  logic             len_valid;
  logic             len_ready;
  logic [CNT_W-1:0] len_data;
  logic             len_sat;
  logic             busy;
`ifdef RUN_LEN_METER_DROPCNT_EN
  logic [15:0]      drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  run_len_meter #(
    .CNT_W (CNT_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .len_data  (len_data),
    .len_sat   (len_sat),
    .busy      (busy)
`ifdef RUN_LEN_METER_DROPCNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are changed 1 time unit after an edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // High for len cycles, then one low sample that terminates the run.
  task automatic run(input int len);
    in = 1'b1;
    repeat (len) step();
    in = 1'b0;
    step();
  endtask

  task automatic pop_expect(input string tag, input int exp_len, input int exp_sat);
    chk({tag, "_valid"}, int'(len_valid), 1);
    chk({tag, "_len"}, int'(len_data), exp_len);
    chk({tag, "_sat"}, int'(len_sat), exp_sat);
    len_ready = 1'b1;
    step();
    len_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in = 1'b0; len_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_valid", int'(len_valid), 0);
    chk("rst_data", int'(len_data), 0);
    chk("rst_sat", int'(len_sat), 0);
    chk("rst_busy", int'(busy), 0);
`ifdef RUN_LEN_METER_DROPCNT_EN
    chk("rst_drop", int'(drop_cnt), 0);
`endif

    // Run of 3: busy through the terminating edge, record one cycle after it.
    in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r3_busy", int'(busy), 1);
      chk("r3_novalid", int'(len_valid), 0);
    end
    in = 1'b0;
    step();
    chk("r3_busy_end", int'(busy), 0);
    pop_expect("r3", 3, 0);
    chk("r3_empty", int'(len_valid), 0);

    // Back-to-back 1,0,1,0 with consumer always ready.
    len_ready = 1'b1;
    in = 1'b1; step();
    in = 1'b0; step();
    chk("b2b_v1", int'(len_valid), 1);
    chk("b2b_d1", int'(len_data), 1);
    in = 1'b1; step();
    chk("b2b_gap", int'(len_valid), 0);
    in = 1'b0; step();
    chk("b2b_v2", int'(len_valid), 1);
    chk("b2b_d2", int'(len_data), 1);
    step();
    chk("b2b_empty", int'(len_valid), 0);
    len_ready = 1'b0;

    // Saturation boundaries at CNT_W=4 (max 15).
    run(20);
    pop_expect("sat20", 15, 1);
    run(15);
    pop_expect("sat15", 15, 1);
    run(14);
    pop_expect("run14", 14, 0);
    chk("sat_empty", int'(len_valid), 0);

    // Overflow: six runs into a stalled FIFO, first four kept.
    for (int i = 1; i <= 6; i++) run(i);
    chk("ovf_valid", int'(len_valid), 1);
`ifdef RUN_LEN_METER_DROPCNT_EN
    chk("ovf_drop", int'(drop_cnt), 2);
`endif
    for (int i = 1; i <= 4; i++) pop_expect("ovf_drain", i, 0);
    chk("ovf_empty", int'(len_valid), 0);

    // Full FIFO with push and pop on the same edge.
    for (int i = 1; i <= 4; i++) run(i);
    in = 1'b1;
    repeat (5) step();
    in = 1'b0; len_ready = 1'b1;
    step();
    len_ready = 1'b0;
`ifdef RUN_LEN_METER_DROPCNT_EN
    chk("pp_drop", int'(drop_cnt), 2);
`endif
    for (int i = 2; i <= 5; i++) pop_expect("pp_drain", i, 0);
    chk("pp_empty", int'(len_valid), 0);

    // Reset on the 5th cycle of a run discards it.
    in = 1'b1;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_valid", int'(len_valid), 0);
`ifdef RUN_LEN_METER_DROPCNT_EN
    chk("mrst_drop", int'(drop_cnt), 0);
`endif
    run(2);
    pop_expect("mrst_run2", 2, 0);
    chk("final_empty", int'(len_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
